line_tracker: RTL and testbench

Line-sensor front end that produces the `dirControl` steering code consumed by the drive block. It synchronizes and debounces a 5-element reflectance sensor array and classifies the stable pattern into a turn/veer/hard/stop command. It also tracks line loss with a search-then-halt state machine and flags junctions. It sits between the sensor input pins and the drive and turn-decision logic.

---
 rtl/line_tracker_if.sv | 22 ++
 rtl/line_tracker.sv | 207 ++++++++++++++++++++
 tb/tb_line_tracker.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/line_tracker_if.sv
// Bundle between the line sensor pins and the drive/turn-decision side of line_tracker.
// The master drives the raw sensor bits; the slave returns the steering code and status flags.
interface line_tracker_if;
    logic [4:0] sens;
    logic [3:0] dirControl;
    logic       junction;
    logic       lineLost;

    modport master (
        output sens,
        input  dirControl,
        input  junction,
        input  lineLost
    );

    modport slave (
        input  sens,
        output dirControl,
        output junction,
        output lineLost
    );
endinterface

// File: rtl/line_tracker.sv
// Line-sensor front end: 2-flop sync, tick-sampled debounce, pattern classification, line-loss FSM.
// Define LINE_TRACKER_SEARCH_EN to insert a timed SEARCH state between losing the line and halting.
module line_tracker #(
    parameter int unsigned SAMPLE_DIV   = 50_000,
    parameter int unsigned FILT_LEN     = 4,
    parameter int unsigned LOST_TIMEOUT = 200
) (
    input  logic          clk,
    input  logic          rst,
    line_tracker_if.slave bus
);
    localparam int unsigned       TICK_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [3:0]        FILT_MAX  = 4'(FILT_LEN);
    localparam logic [3:0]        DC_HALT   = 4'b1111;
    localparam logic [4:0]        PAT_NONE  = 5'b00000;
    localparam logic [4:0]        PAT_ALL   = 5'b11111;

`ifdef LINE_TRACKER_SEARCH_EN
    localparam logic [15:0]       LOST_LAST = 16'(LOST_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_TRACK  = 2'd0,
        ST_SEARCH = 2'd1,
        ST_HALT   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_TRACK  = 2'd0,
        ST_HALT   = 2'd2
    } state_t;
`endif

    logic [4:0]        sens_meta_reg;
    logic [4:0]        sens_sync_reg;
    logic [TICK_W-1:0] tick_cnt_reg;
    logic              tick;
    logic [4:0]        cand_reg;
    logic [4:0]        cand_next;
    logic [3:0]        stable_reg;
    logic [3:0]        stable_next;
    logic [3:0]        stable_inc;
    logic              accept;
    logic              cls_valid;
    logic [3:0]        cls_code;
    state_t            state_reg;
    state_t            state_next;
    logic [3:0]        dir_reg;
    logic [3:0]        dir_next;
    logic              junction_reg;
    logic              junction_next;
`ifdef LINE_TRACKER_SEARCH_EN
    logic [15:0]       lost_cnt_reg;
    logic [15:0]       lost_cnt_next;
`endif

    // Sensors are asynchronous to clk: two flops before anything looks at them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sens_meta_reg <= 5'b00000;
            sens_sync_reg <= 5'b00000;
        end else begin
            sens_meta_reg <= bus.sens;
            sens_sync_reg <= sens_meta_reg;
        end
    end

    assign tick = (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
        end
    end

    assign stable_inc = stable_reg + 4'd1;

    // Debounce: a pattern is accepted once when its run reaches FILT_LEN ticks;
    // the all-zero pattern keeps re-accepting while saturated so the loss timer can run.
    always_comb begin
        cand_next   = cand_reg;
        stable_next = stable_reg;
        accept      = 1'b0;
        if (tick) begin
            if (sens_sync_reg == cand_reg) begin
                if (stable_reg == FILT_MAX) begin
                    accept = (cand_reg == PAT_NONE);
                end else begin
                    stable_next = stable_inc;
                    accept      = (stable_inc == FILT_MAX);
                end
            end else begin
                cand_next   = sens_sync_reg;
                stable_next = 4'd1;
                accept      = (FILT_MAX == 4'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_reg   <= 5'b00000;
            stable_reg <= 4'd0;
        end else begin
            cand_reg   <= cand_next;
            stable_reg <= stable_next;
        end
    end

    // The accepted pattern is always the current synchronized sample.
    always_comb begin
        cls_valid = 1'b1;
        cls_code  = 4'b0000;
        case (sens_sync_reg)
            5'b00100:           cls_code = 4'b0000;
            5'b01100, 5'b01000: cls_code = 4'b0101;
            5'b00110, 5'b00010: cls_code = 4'b1001;
            5'b11000, 5'b10000: cls_code = 4'b0110;
            5'b00011, 5'b00001: cls_code = 4'b1010;
            5'b11100, 5'b11110: cls_code = 4'b0111;
            5'b00111, 5'b01111: cls_code = 4'b1011;
            5'b11111:           cls_code = 4'b1111;
            default:            cls_valid = 1'b0;
        endcase
    end

`ifdef LINE_TRACKER_SEARCH_EN
    // Keep turning the way we last turned, but harder, while looking for the line.
    function automatic logic [3:0] search_code(input logic [1:0] turn);
        case (turn)
            2'b01:   return 4'b0110;
            2'b10:   return 4'b1010;
            2'b00:   return 4'b0000;
            default: return 4'b1111;
        endcase
    endfunction
`endif

    always_comb begin
        state_next    = state_reg;
        dir_next      = dir_reg;
        junction_next = 1'b0;
`ifdef LINE_TRACKER_SEARCH_EN
        lost_cnt_next = lost_cnt_reg;
`endif
        if (accept) begin
            if (sens_sync_reg == PAT_NONE) begin
                case (state_reg)
                    ST_TRACK: begin
`ifdef LINE_TRACKER_SEARCH_EN
                        state_next    = ST_SEARCH;
                        lost_cnt_next = 16'd0;
                        dir_next      = search_code(dir_reg[3:2]);
`else
                        state_next    = ST_HALT;
                        dir_next      = DC_HALT;
`endif
                    end
`ifdef LINE_TRACKER_SEARCH_EN
                    ST_SEARCH: begin
                        if (lost_cnt_reg == LOST_LAST) begin
                            state_next = ST_HALT;
                            dir_next   = DC_HALT;
                        end else begin
                            lost_cnt_next = lost_cnt_reg + 16'd1;
                        end
                    end
`endif
                    default: begin
                        state_next = state_reg;
                    end
                endcase
            end else if (cls_valid) begin
                state_next    = ST_TRACK;
                dir_next      = cls_code;
                junction_next = (sens_sync_reg == PAT_ALL);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_TRACK;
            dir_reg      <= DC_HALT;
            junction_reg <= 1'b0;
`ifdef LINE_TRACKER_SEARCH_EN
            lost_cnt_reg <= 16'd0;
`endif
        end else begin
            state_reg    <= state_next;
            dir_reg      <= dir_next;
            junction_reg <= junction_next;
`ifdef LINE_TRACKER_SEARCH_EN
            lost_cnt_reg <= lost_cnt_next;
`endif
        end
    end

    assign bus.dirControl = dir_reg;
    assign bus.junction   = junction_reg;
    assign bus.lineLost   = (state_reg != ST_TRACK);

endmodule

// File: tb/tb_line_tracker.sv
// Bench for line_tracker: directed scenarios plus random sensor sequences,
// every cycle compared against a run-length reference model of the tracker.
module tb_line_tracker;
    localparam int SD = 4;
    localparam int FL = 3;
    localparam int LT = 5;
    localparam int M_TRACK  = 0;
    localparam int M_SEARCH = 1;
    localparam int M_HALT   = 2;

    logic clk = 1'b0;
    logic rst;

    line_tracker_if lt_if ();

    line_tracker #(
        .SAMPLE_DIV  (SD),
        .FILT_LEN    (FL),
        .LOST_TIMEOUT(LT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(lt_if)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit search_en;

    // Reference model: pipeline of sensor samples, run length of identical tick samples.
    logic [4:0] m_meta, m_sync, run_pat;
    int         m_phase, run_len, m_mode, m_zeros, jpulses;
    logic [3:0] m_dir;
    logic       m_junc;

    logic [4:0] pats [16] = '{5'b00100, 5'b01100, 5'b01000, 5'b00110, 5'b00010, 5'b11000,
                              5'b10000, 5'b00011, 5'b00001, 5'b11100, 5'b00111, 5'b11111,
                              5'b00000, 5'b00000, 5'b01010, 5'b10101};

    function automatic int classify(input logic [4:0] p);
        case (p)
            5'b00100:           return int'(4'b0000);
            5'b01100, 5'b01000: return int'(4'b0101);
            5'b00110, 5'b00010: return int'(4'b1001);
            5'b11000, 5'b10000: return int'(4'b0110);
            5'b00011, 5'b00001: return int'(4'b1010);
            5'b11100, 5'b11110: return int'(4'b0111);
            5'b00111, 5'b01111: return int'(4'b1011);
            5'b11111:           return int'(4'b1111);
            default:            return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_meta = '0; m_sync = '0; run_pat = '0; run_len = 0; m_phase = 0;
        m_mode = M_TRACK; m_zeros = 0; m_dir = 4'b1111; m_junc = 1'b0;
    endtask

    task automatic apply_accept(input logic [4:0] p);
        int code;
        code = classify(p);
        if (p == 5'b00000) begin
            if (m_mode == M_TRACK) begin
                if (search_en) begin
                    m_mode  = M_SEARCH;
                    m_zeros = 0;
                    case (m_dir[3:2])
                        2'b01:   m_dir = 4'b0110;
                        2'b10:   m_dir = 4'b1010;
                        2'b00:   m_dir = 4'b0000;
                        default: m_dir = 4'b1111;
                    endcase
                end else begin
                    m_mode = M_HALT;
                    m_dir  = 4'b1111;
                end
            end else if (m_mode == M_SEARCH) begin
                m_zeros++;
                if (m_zeros == LT) begin
                    m_mode = M_HALT;
                    m_dir  = 4'b1111;
                end
            end
        end else if (code >= 0) begin
            m_mode = M_TRACK;
            m_dir  = code[3:0];
            m_junc = (p == 5'b11111);
        end
    endtask

    task automatic model_edge(input logic [4:0] s);
        m_junc = 1'b0;
        if (m_phase == SD - 1) begin
            if (m_sync == run_pat) run_len++;
            else begin
                run_pat = m_sync;
                run_len = 1;
            end
            if (run_len == FL || (run_pat == 5'b00000 && run_len > FL)) apply_accept(run_pat);
        end
        m_sync  = m_meta;
        m_meta  = s;
        m_phase = (m_phase + 1) % SD;
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s t=%0t observed %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic cyc();
        logic [4:0] s;
        s = lt_if.sens;
        @(posedge clk);
        model_edge(s);
        #1;
        check("dir", lt_if.dirControl, m_dir);
        check("junction", {3'b000, lt_if.junction}, {3'b000, m_junc});
        check("lineLost", {3'b000, lt_if.lineLost}, {3'b000, (m_mode != M_TRACK)});
        if (lt_if.junction === 1'b1) jpulses++;
    endtask

    task automatic hold(input logic [4:0] p, input int n);
        lt_if.sens = p;
        repeat (n) cyc();
    endtask

    // Reset pulse placed between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        #1 rst = 1'b0;
        #1;
        check("rst_dir", lt_if.dirControl, 4'b1111);
        check("rst_junction", {3'b000, lt_if.junction}, 4'b0000);
        check("rst_lineLost", {3'b000, lt_if.lineLost}, 4'b0000);
        model_reset();
        #1 rst = 1'b1;
    endtask

    initial begin
        int waited;
        int glitch_bad;
`ifdef LINE_TRACKER_SEARCH_EN
        search_en = 1'b1;
`else
        search_en = 1'b0;
`endif
        rst = 1'b1;
        lt_if.sens = 5'b00000;
        jpulses = 0;
        do_reset();

        hold(5'b00000, 20);
        check("reset_zero_lost", {3'b000, lt_if.lineLost}, 4'b0001);

        hold(5'b00100, 20); check("cls_00100", lt_if.dirControl, 4'b0000);
        hold(5'b01100, 20); check("cls_01100", lt_if.dirControl, 4'b0101);
        hold(5'b11000, 20); check("cls_11000", lt_if.dirControl, 4'b0110);
        hold(5'b00111, 20); check("cls_00111", lt_if.dirControl, 4'b1011);

        hold(5'b00100, 20);
        glitch_bad = 0;
        lt_if.sens = 5'b10000;
        repeat (8) begin
            cyc();
            if (lt_if.dirControl !== 4'b0000) glitch_bad++;
        end
        lt_if.sens = 5'b00100;
        repeat (20) begin
            cyc();
            if (lt_if.dirControl !== 4'b0000) glitch_bad++;
        end
        check("glitch_changes", 4'(glitch_bad), 4'd0);

        hold(5'b00100, 20);
        jpulses = 0;
        hold(5'b11111, 40);
        check("junction_dir", lt_if.dirControl, 4'b1111);
        check("junction_pulses", 4'(jpulses), 4'd1);
        hold(5'b01010, 20);
        check("invalid_hold", lt_if.dirControl, 4'b1111);

        hold(5'b11000, 20);
        check("loss_start", lt_if.dirControl, 4'b0110);
        lt_if.sens = 5'b00000;
        waited = 0;
        while (lt_if.lineLost !== 1'b1 && waited < 40) begin
            cyc();
            waited++;
        end
        check("loss_seen", {3'b000, lt_if.lineLost}, 4'b0001);
        check("loss_code", lt_if.dirControl, search_en ? 4'b0110 : 4'b1111);
        hold(5'b00000, 40);
        check("halt_dir", lt_if.dirControl, 4'b1111);
        check("halt_lost", {3'b000, lt_if.lineLost}, 4'b0001);
        hold(5'b00010, 20);
        check("recover_dir", lt_if.dirControl, 4'b1001);
        check("recover_lost", {3'b000, lt_if.lineLost}, 4'b0000);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0) do_reset();
            hold(pats[$urandom_range(0, 15)], int'($urandom_range(1, 30)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
